arb_rr_param: RTL and testbench
===============================

ARB_RR_PARAM -- requirements
Module: arb_rr_param

Interface
REQ-001 Parameter N, default 4: number of requesters; legal range 2..16.
REQ-002 Parameter MAX_HOLD, default 8: maximum consecutive grant cycles per holder when timeout is compiled in; legal range 2..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 request  input  N  per-channel request, level-sensitive; bit i high means channel i wants the resource.
REQ-006 mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins); sampled every cycle.
REQ-007 grant  output  N  registered one-hot-or-zero grant vector.
REQ-008 grant_vld  output  1  registered; high when grant is nonzero.
REQ-009 grant_id  output  $clog2(N)  registered index of the granted channel; 0 when grant_vld is low.

Function
REQ-010 Latency: request sampled at edge k SHALL produce grant at edge k+1 when the resource is free; no combinational path from request to grant.
REQ-011 Lock: while the current holder's request stays high, grant SHALL remain on that holder, except as in REQ-016.
REQ-012 Release: when the holder's request is low at an edge, arbitration among current requests SHALL occur at that same edge; the new winner is granted with no idle bubble; grant goes to zero only if no request is high.
REQ-013 Round-robin (mode=0): search SHALL start at last_id+1 and wrap modulo N; last_id is the most recently granted index and is retained across idle cycles.
REQ-014 Fixed priority (mode=1): lowest-index active request SHALL win; lock rule REQ-011 still applies; last_id still updates.
REQ-015 States: IDLE (grant_vld=0) and BUSY (grant_vld=1); IDLE->BUSY on any request; BUSY->IDLE when holder drops and no other request; BUSY->BUSY on hand-over.
REQ-016 Hold counter (only with ARB_TIMEOUT_EN): counts holder cycles from 1; when it reaches MAX_HOLD and another channel requests, next edge SHALL hand grant to the next winner per mode, excluding the holder; if no other request, holder keeps grant and counter saturates at MAX_HOLD.
REQ-017 Counter SHALL reload to 1 on every new grant and clear in IDLE.
REQ-018 Mode change while BUSY SHALL NOT revoke the current grant; it applies at the next arbitration.
REQ-019 grant SHALL never have more than one bit set.

Reset
REQ-020 With rst high at an edge: grant=0, grant_vld=0, grant_id=0, state IDLE, hold counter=0, last_id=N-1 (so first round-robin search starts at channel 0).
REQ-021 Reset mid-grant SHALL drop grant at that same edge regardless of request; arbitration resumes the first edge after rst falls.

Configuration
REQ-022 Macro ARB_TIMEOUT_EN: defined -> hold counter and forced rotation per REQ-016/017 present; undefined -> no counter logic, holder keeps grant indefinitely while requesting, MAX_HOLD ignored.

Verification (N=4, MAX_HOLD=4)
REQ-023 Reset then request=4'b0000 -> grant=0, grant_vld=0, grant_id=0 for all cycles.
REQ-024 mode=0, request=4'b1111 held, each holder drops request for one cycle after being granted -> grant sequence 0001,0010,0100,1000,0001; no idle cycle between.
REQ-025 mode=1, request=4'b1010 -> grant=0010 one cycle later; drop bit1 -> grant=1000 next edge; then request 4'b1001 -> grant stays 1000 (lock).
REQ-026 ARB_TIMEOUT_EN defined, mode=0, request=4'b0011 held -> grant 0001 for 4 cycles, then 0010 for 4 cycles, alternating; undefined -> 0001 forever.
REQ-027 grant=0100 active, assert rst one cycle -> grant=0 at that edge; after release with request=4'b0100 -> grant=0100 one cycle later.

Source files
------------

// File: rtl/arb_rr_param.sv
// N-way lock-until-release arbiter: round-robin (mode=0) or fixed priority (mode=1); optional hold timeout under ARB_TIMEOUT_EN.
// Latency: request sampled at edge k gives a registered grant at edge k+1; no combinational request-to-grant path.
// Backpressure: none; the holder keeps the grant while requesting, or until the hold limit if the timeout is compiled in.
module arb_rr_param #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         request,
  input  logic                 mode,
  output logic [N-1:0]         grant,
  output logic                 grant_vld,
  output logic [$clog2(N)-1:0] grant_id
);

  localparam int IW = $clog2(N);

  if (N < 2 || N > 16) begin : g_bad_n
    $error("arb_rr_param: N out of range 2..16");
  end
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("arb_rr_param: MAX_HOLD out of range 2..255");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [IW-1:0]   grant_id_q, grant_id_d;
  logic [IW-1:0]   last_id_q, last_id_d;

  logic [N-1:0]    cand;
  logic            do_arb;
  logic            holder_req;
  logic            found;
  logic [IW-1:0]   win_id;
  logic [IW:0]     rr_sum;
  logic [IW-1:0]   rr_idx;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            hold_expired;
  assign hold_expired = (cnt_q >= CW'(MAX_HOLD));
`endif

  // Winner search over cand; round-robin starts just after last_id and wraps.
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    rr_sum = '0;
    rr_idx = '0;
    if (mode) begin
      for (int i = 0; i < N; i++) begin
        if (!found && cand[i]) begin
          found  = 1'b1;
          win_id = IW'(i);
        end
      end
    end else begin
      for (int i = 1; i <= N; i++) begin
        rr_sum = {1'b0, last_id_q} + (IW+1)'(i);
        if (rr_sum >= (IW+1)'(N)) begin
          rr_sum = rr_sum - (IW+1)'(N);
        end
        rr_idx = rr_sum[IW-1:0];
        if (!found && cand[rr_idx]) begin
          found  = 1'b1;
          win_id = rr_idx;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    last_id_d  = last_id_q;
    cand       = '0;
    do_arb     = 1'b0;
    holder_req = (state_q == BUSY) && |(request & grant_q);

    if (holder_req) begin
`ifdef ARB_TIMEOUT_EN
      // Forced rotation only if someone else is waiting; the holder is excluded.
      if (hold_expired && |(request & ~grant_q)) begin
        do_arb = 1'b1;
        cand   = request & ~grant_q;
      end
`endif
    end else begin
      do_arb = 1'b1;
      cand   = request;
    end

    if (do_arb) begin
      if (found) begin
        state_d    = BUSY;
        grant_d    = {{(N-1){1'b0}}, 1'b1} << win_id;
        grant_id_d = win_id;
        last_id_d  = win_id;
      end else begin
        state_d    = IDLE;
        grant_d    = '0;
        grant_id_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      last_id_q  <= IW'(N - 1);
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      last_id_q  <= last_id_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_comb begin
    cnt_d = cnt_q;
    if (state_d == IDLE) begin
      cnt_d = '0;
    end else if (do_arb) begin
      cnt_d = CW'(1);
    end else if (!hold_expired) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign grant     = grant_q;
  assign grant_vld = (state_q == BUSY);
  assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_arb_rr_param.sv
// Directed bench for arb_rr_param with N=4, MAX_HOLD=4; follows ARB_TIMEOUT_EN for the hold tests.
module tb_arb_rr_param;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode;
  logic [3:0] request;
  logic [3:0] grant;
  logic       grant_vld;
  logic [1:0] grant_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arb_rr_param #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .request   (request),
    .mode      (mode),
    .grant     (grant),
    .grant_vld (grant_vld),
    .grant_id  (grant_id)
  );

  // Advance one edge and settle; outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b0; request = 4'b0000;
    step();
    checks++;
    if ({grant, grant_vld, grant_id} !== 7'b0000_0_00) begin
      errors++;
      $display("FAIL reset_state: got grant=%b vld=%b id=%0d, want 0000/0/0", grant, grant_vld, grant_id);
    end
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if ({grant, grant_vld, grant_id} !== 7'b0000_0_00) begin
        errors++;
        $display("FAIL idle_no_req c%0d: got grant=%b vld=%b id=%0d, want 0000/0/0", c, grant, grant_vld, grant_id);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] reqs [5] = '{4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [3:0] exps [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] ids  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    mode = 1'b0;
    for (int k = 0; k < 5; k++) begin
      request = reqs[k];
      step();
      checks++;
      if (grant !== exps[k] || grant_vld !== 1'b1 || grant_id !== ids[k] || $countones(grant) > 1) begin
        errors++;
        $display("FAIL rr_seq k%0d: got grant=%b vld=%b id=%0d, want %b/1/%0d", k, grant, grant_vld, grant_id, exps[k], ids[k]);
      end
    end
    request = 4'b0000;
    step();
    checks++;
    if ({grant, grant_vld, grant_id} !== 7'b0000_0_00) begin
      errors++;
      $display("FAIL rr_release_idle: got grant=%b vld=%b id=%0d, want 0000/0/0", grant, grant_vld, grant_id);
    end
  endtask

  task automatic test_fixed_priority();
    logic [3:0] reqs [4] = '{4'b1010, 4'b1000, 4'b1001, 4'b1001};
    logic [3:0] exps [4] = '{4'b0010, 4'b1000, 4'b1000, 4'b1000};
    logic [1:0] ids  [4] = '{2'd1, 2'd3, 2'd3, 2'd3};
    mode = 1'b1;
    for (int k = 0; k < 4; k++) begin
      request = reqs[k];
      step();
      checks++;
      if (grant !== exps[k] || grant_vld !== 1'b1 || grant_id !== ids[k]) begin
        errors++;
        $display("FAIL fixed_seq k%0d: got grant=%b vld=%b id=%0d, want %b/1/%0d", k, grant, grant_vld, grant_id, exps[k], ids[k]);
      end
    end
    request = 4'b0000;
    step();
  endtask

  // Mode flips while busy keep the holder; the next arbitration uses the new mode.
  task automatic test_mode_change();
    mode = 1'b0; request = 4'b1100;
    step();
    checks++;
    if (grant !== 4'b0100 || grant_id !== 2'd2) begin
      errors++;
      $display("FAIL mode_rr_start: got grant=%b id=%0d, want 0100/2", grant, grant_id);
    end
    mode = 1'b1; request = 4'b1101;
    step();
    checks++;
    if (grant !== 4'b0100 || grant_id !== 2'd2) begin
      errors++;
      $display("FAIL mode_no_revoke: got grant=%b id=%0d, want 0100/2", grant, grant_id);
    end
    request = 4'b1001;
    step();
    checks++;
    if (grant !== 4'b0001 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL mode_fixed_applied: got grant=%b id=%0d, want 0001/0", grant, grant_id);
    end
    request = 4'b0000;
    step(); step(); step();
    mode = 1'b0; request = 4'b1011;
    step();
    checks++;
    if (grant !== 4'b0010 || grant_id !== 2'd1) begin
      errors++;
      $display("FAIL rr_last_id_kept: got grant=%b id=%0d, want 0010/1", grant, grant_id);
    end
    request = 4'b0000;
    step();
  endtask

  task automatic test_hold_timeout();
    logic [3:0] exp_g;
    rst = 1'b1; request = 4'b0000; mode = 1'b0;
    step();
    rst = 1'b0;
    request = 4'b0011;
    for (int c = 0; c < 12; c++) begin
      step();
`ifdef ARB_TIMEOUT_EN
      exp_g = (((c / MAX_HOLD) % 2) == 0) ? 4'b0001 : 4'b0010;
`else
      exp_g = 4'b0001;
`endif
      checks++;
      if (grant !== exp_g || grant_vld !== 1'b1) begin
        errors++;
        $display("FAIL hold_alternate c%0d: got grant=%b vld=%b, want %b/1", c, grant, grant_vld, exp_g);
      end
    end
    request = 4'b0000;
    step();
    request = 4'b0001;
    for (int c = 0; c < 6; c++) begin
      step();
      checks++;
      if (grant !== 4'b0001) begin
        errors++;
        $display("FAIL hold_alone c%0d: got grant=%b, want 0001", c, grant);
      end
    end
    request = 4'b0011;
    step();
`ifdef ARB_TIMEOUT_EN
    exp_g = 4'b0010;
`else
    exp_g = 4'b0001;
`endif
    checks++;
    if (grant !== exp_g) begin
      errors++;
      $display("FAIL hold_saturated: got grant=%b, want %b", grant, exp_g);
    end
    request = 4'b0000;
    step();
  endtask

  task automatic test_reset_mid_grant();
    mode = 1'b0; request = 4'b0100;
    step();
    checks++;
    if (grant !== 4'b0100 || grant_id !== 2'd2) begin
      errors++;
      $display("FAIL rstmid_pre: got grant=%b id=%0d, want 0100/2", grant, grant_id);
    end
    rst = 1'b1;
    step();
    checks++;
    if ({grant, grant_vld, grant_id} !== 7'b0000_0_00) begin
      errors++;
      $display("FAIL rstmid_drop: got grant=%b vld=%b id=%0d, want 0000/0/0", grant, grant_vld, grant_id);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({grant, grant_vld, grant_id} !== 7'b0100_1_10) begin
      errors++;
      $display("FAIL rstmid_resume: got grant=%b vld=%b id=%0d, want 0100/1/2", grant, grant_vld, grant_id);
    end
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; request = 4'b0000;
    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_mode_change();
    test_hold_timeout();
    test_reset_mid_grant();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
